// File: rtl/prog_loader.sv
// Boot-time program loader: assembles instruction/data words from a byte stream,
// writes them through the CPU memory write ports, and releases CPU reset on RUN.
module prog_loader #(
  parameter int IW = 32,
  parameter int DW = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          err,
  output logic [15:0]   wr_count
);

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'hFF;
  localparam logic [2:0] IMEM_LAST = 3'(IW / 8 - 1);
  localparam logic [2:0] DMEM_LAST = 3'(DW / 8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_INDEX, S_DATA, S_WRITE, S_RUN} state_e;

  state_e          state_q;
  logic            is_dmem_q;
  logic [AW-1:0]   idx_q;
  logic [2:0]      byte_cnt_q;
  logic [DW-1:0]   asm_q;
  logic [DW-1:0]   asm_d;
  logic            imem_we_q;
  logic [AW-1:0]   imem_addr_q;
  logic [IW-1:0]   imem_wdata_q;
  logic            dmem_we_q;
  logic [AW-1:0]   dmem_addr_q;
  logic [DW-1:0]   dmem_wdata_q;
  logic            cpu_reset_q;
  logic            done_q;
  logic            err_q;
  logic [15:0]     wr_count_q;
  logic            accept;
  logic            last_byte;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_INDEX) || (state_q == S_DATA);
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt_q == (is_dmem_q ? DMEM_LAST : IMEM_LAST));

  // NOTE: assign a default first so no path through always_comb infers a latch.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      is_dmem_q    <= 1'b0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
            is_dmem_q <= (in_data == CMD_DMEM);
            state_q   <= S_INDEX;
          end else if (in_data == CMD_RUN) begin
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_RUN;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_INDEX: if (accept) begin
          idx_q      <= in_data[AW-1:0];
          byte_cnt_q <= '0;
          asm_q      <= '0;
          state_q    <= S_DATA;
        end
        S_DATA: if (accept) begin
          asm_q      <= asm_d;
          byte_cnt_q <= byte_cnt_q + 3'd1;
          if (last_byte) begin
            state_q <= S_WRITE;
            // Address/data registers only change on their own memory's write.
            if (is_dmem_q) begin
              dmem_we_q    <= 1'b1;
              dmem_addr_q  <= idx_q;
              dmem_wdata_q <= asm_d;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= idx_q;
              imem_wdata_q <= asm_d[IW-1:0];
            end
          end
        end
        S_WRITE: begin
          imem_we_q <= 1'b0;
          dmem_we_q <= 1'b0;
          if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
          state_q <= S_IDLE;
        end
        S_RUN: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random packet streams compared
// against a packet-level parse of the accepted byte stream.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] wr_count;

  typedef struct packed {
    logic        is_d;
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 0;
  bit          prev_we = 0;
  logic [7:0]  stream_q[$];
  wr_t         obs_q[$];

  prog_loader #(.IW(32), .DW(64), .AW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol properties plus capture of every write strobe.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("ready_vs_write", in_ready, !(imem_we || dmem_we) && !done);
      check("we_exclusive", imem_we && dmem_we, 0);
      check("we_single_cycle", (imem_we || dmem_we) && prev_we, 0);
      prev_we = imem_we || dmem_we;
      if (imem_we) obs_q.push_back({1'b0, imem_addr, 32'h0, imem_wdata});
      if (dmem_we) obs_q.push_back({1'b1, dmem_addr, dmem_wdata});
    end else begin
      prev_we = 0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_dmem_we"}, dmem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_dmem_addr"}, dmem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_wr_count"}, wr_count, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1;
    in_valid = 0;
    @(posedge clk);
    #1;
    check_reset_vals(tag);
    obs_q.delete();
    stream_q.delete();
    @(negedge clk);
    reset = 0;
  endtask

  // Present one byte, optionally after random idle gaps, and hold it until taken.
  task automatic send(input logic [7:0] b, input bit gappy);
    int waited;
    int gaps;
    waited = 0;
    gaps = 0;
    @(negedge clk);
    if (gappy) begin
      while ($urandom_range(0, 2) == 0 && gaps < 4) begin
        in_valid = 0;
        gaps++;
        @(negedge clk);
      end
    end
    in_valid = 1;
    in_data = b;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    stream_q.push_back(b);
  endtask

  task automatic send_pkt(input bit is_d, input logic [7:0] idx, input logic [63:0] data,
                          input bit gappy, input bit lat_check);
    int n;
    n = is_d ? 8 : 4;
    send(is_d ? 8'h02 : 8'h01, gappy);
    send(idx, gappy);
    for (int k = 0; k < n; k++) send(data[8*k +: 8], gappy);
    if (lat_check) begin
      @(negedge clk);
      in_valid = 0;
      if (is_d) begin
        check("lat_dmem_we", dmem_we, 1);
        check("lat_dmem_addr", dmem_addr, idx);
        check("lat_dmem_wdata", dmem_wdata, data);
      end else begin
        check("lat_imem_we", imem_we, 1);
        check("lat_imem_addr", imem_addr, idx);
        check("lat_imem_wdata", imem_wdata, data[31:0]);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  // Reference: parse the accepted byte stream packet by packet.
  task automatic check_stream(input string tag);
    wr_t        exp_q[$];
    wr_t        w;
    bit         e_err;
    bit         e_run;
    int         i;
    int         n;
    logic [7:0] c;
    i = 0;
    e_err = 0;
    e_run = 0;
    while (i < stream_q.size() && !e_run) begin
      c = stream_q[i];
      if (c == 8'h01 || c == 8'h02) begin
        n = (c == 8'h02) ? 8 : 4;
        if (i + n + 2 > stream_q.size()) break;
        w.is_d = (c == 8'h02);
        w.addr = stream_q[i+1];
        w.data = '0;
        for (int k = 0; k < n; k++) w.data[8*k +: 8] = stream_q[i+2+k];
        exp_q.push_back(w);
        i += n + 2;
      end else if (c == 8'hFF) begin
        e_run = 1;
      end else begin
        e_err = 1;
        i++;
      end
    end
    check({tag, "_num_writes"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check($sformatf("%s_write%0d", tag, k), obs_q[k], exp_q[k]);
    check({tag, "_err"}, err, e_err);
    check({tag, "_done"}, done, e_run);
    check({tag, "_cpu_reset"}, cpu_reset, !e_run);
    check({tag, "_wr_count"}, wr_count, exp_q.size());
  endtask

  initial begin
    logic [7:0] trail[6];
    logic [7:0] b;
    clk = 0;
    reset = 0;
    in_valid = 0;
    in_data = 0;
    #2 reset = 1;
    @(posedge clk);
    #1;
    check_reset_vals("por");
    mon_en = 1;
    @(negedge clk);
    reset = 0;

    // Basic imem packet at full rate.
    send_pkt(0, 8'h00, 64'h8C080000, 0, 1);
    idle(3);
    check("imem0_wdata", imem_wdata, 32'h8C080000);
    check_stream("imem0");

    // dmem packet carrying -400.
    send_pkt(1, 8'h03, 64'hFFFFFFFFFFFFFE70, 0, 1);
    idle(3);
    check("dmem3_wdata", dmem_wdata, 64'hFFFFFFFFFFFFFE70);
    check_stream("dmem3");

    // Same packet with random valid gaps, then with the next packet held through WRITE.
    send_pkt(1, 8'h03, 64'hFFFFFFFFFFFFFE70, 1, 1);
    send_pkt(1, 8'h03, 64'hFFFFFFFFFFFFFE70, 0, 0);
    send_pkt(0, 8'h05, {32'h0, $urandom}, 0, 1);
    idle(3);
    check_stream("gaps_held");

    // Unknown command byte is flagged and dropped.
    do_reset("rst_err");
    send(8'h55, 0);
    #1;
    check("err_after_55", err, 1);
    send_pkt(0, 8'h0C, 64'h1000FFFF, 0, 1);
    idle(3);
    check("err_wr_count", wr_count, 1);
    check_stream("err_pkt");

    // Random mix of packets and junk bytes.
    do_reset("rst_rand");
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h01 || b == 8'h02 || b == 8'hFF);
        send(b, 1);
      end else begin
        send_pkt(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
      end
    end
    idle(3);
    check_stream("random");

    // Program load followed by RUN and ignored trailing bytes.
    do_reset("rst_prog");
    for (int k = 0; k < 13; k++) send_pkt(0, 8'(k), {32'h0, $urandom}, 0, 1);
    for (int k = 0; k < 7; k++) send_pkt(1, 8'(k), {$urandom, $urandom}, 0, 1);
    idle(2);
    check("pre_run_cpu_reset", cpu_reset, 1);
    send(8'hFF, 0);
    #1;
    check("run_cpu_reset", cpu_reset, 0);
    check("run_done", done, 1);
    trail = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1;
      in_data = trail[k];
      check("trail_in_ready", in_ready, 0);
    end
    idle(3);
    check_stream("prog_run");

    // Reset mid-packet discards the partial packet.
    do_reset("rst_pre");
    send(8'h02, 0);
    send(8'h01, 0);
    send(8'hC8, 0);
    idle(1);
    check("partial_no_write", obs_q.size(), 0);
    do_reset("rst_mid");
    send_pkt(1, 8'h01, 64'd200, 0, 1);
    idle(3);
    check("post_reset_wdata", dmem_wdata, 64'd200);
    check_stream("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
